// File: rtl/five_bit_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : five_bit_operand_sequencer
//  Description : Captures operand A then operand B from a shared switch bus
//                on successive debounced load presses, drives both operands
//                to an external ripple adder, and holds the registered
//                {cout,sum} result with a valid flag.
//  Revision    : 1.0  initial release
// ============================================================================
module five_bit_operand_sequencer #(
    parameter int WIDTH    = 5,
    parameter int SYNC_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             load_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             cout_i,
    output logic [WIDTH:0]   result_o,
    output logic             result_valid_o,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GOT_A = 2'b01,
        ADD   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_LEN-1:0] sync_q;
    logic                edge_q;
    logic                ld_pulse;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             valid_q, valid_d;

    // Synchronise the raw button level and remember the last synced level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_LEN-2:0], load_i};
            edge_q <= sync_q[SYNC_LEN-1];
        end
    end

    // One-cycle pulse per 0->1 transition of the synchronised level.
    assign ld_pulse = sync_q[SYNC_LEN-1] & ~edge_q;

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state and register-update decode; everything holds unless a step fires.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE, DONE: begin
                // A new addition starts here; B keeps its old value until recaptured.
                if (ld_pulse) begin
                    a_d     = data_in_i;
                    valid_d = 1'b0;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                if (ld_pulse) begin
                    b_d     = data_in_i;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Adder has settled from registered A/B; a pulse here is dropped.
                result_d = {cout_i, sum_i};
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_o            = a_q;
    assign b_o            = b_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign state_dbg_o    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_five_bit_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_five_bit_operand_sequencer
//  Description : Self-checking bench for five_bit_operand_sequencer with a
//                behavioural 5-bit adder closing the loop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_five_bit_operand_sequencer;

    localparam int WIDTH = 5;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] data_in_i;
    logic             load_i;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic [WIDTH-1:0] sum_i;
    logic             cout_i;
    logic [WIDTH:0]   result_o;
    logic             result_valid_o;
    logic [1:0]       state_dbg_o;

    logic [WIDTH:0]   w_add;

    int vec_count;
    int miscompares;
    logic [WIDTH:0] sb[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   exp;
    } vec_t;

    vec_t vecs[5];

    five_bit_operand_sequencer #(.WIDTH(WIDTH), .SYNC_LEN(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .data_in_i      (data_in_i),
        .load_i         (load_i),
        .a_o            (a_o),
        .b_o            (b_o),
        .sum_i          (sum_i),
        .cout_i         (cout_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .state_dbg_o    (state_dbg_o)
    );

    // External ripple adder model.
    assign w_add  = {1'b0, a_o} + {1'b0, b_o};
    assign sum_i  = w_add[WIDTH-1:0];
    assign cout_i = w_add[WIDTH];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Press for operand A: capture lands on the third edge after load rises.
    task automatic press_a(input logic [WIDTH-1:0] d);
        data_in_i = d;
        load_i    = 1'b1;
        step(3);
        chk("a_state", state_dbg_o, 1);
        chk("a_value", a_o, d);
        chk("a_valid_cleared", result_valid_o, 0);
        load_i = 1'b0;
        step(3);
    endtask

    // Press for operand B with cycle-exact checks of ADD and the valid rise.
    task automatic press_b(input logic [WIDTH-1:0] d, input logic [WIDTH:0] exp);
        logic [WIDTH:0] e;
        sb.push_back(exp);
        data_in_i = d;
        load_i    = 1'b1;
        step(3);
        chk("b_state_add", state_dbg_o, 2);
        chk("b_value", b_o, d);
        chk("b_valid_early", result_valid_o, 0);
        step(1);
        chk("done_state", state_dbg_o, 3);
        chk("done_valid", result_valid_o, 1);
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk("result", result_o, e);
        end
        load_i = 1'b0;
        step(3);
        chk("done_hold", state_dbg_o, 3);
    endtask

    initial begin
        vec_count   = 0;
        miscompares = 0;
        vecs[0] = '{a: 5'd9,  b: 5'd4,  exp: 6'd13};
        vecs[1] = '{a: 5'd31, b: 5'd31, exp: 6'd62};
        vecs[2] = '{a: 5'd0,  b: 5'd0,  exp: 6'd0};
        vecs[3] = '{a: 5'd17, b: 5'd20, exp: 6'd37};
        vecs[4] = '{a: 5'd31, b: 5'd1,  exp: 6'd32};

        reset     = 1'b1;
        load_i    = 1'b0;
        data_in_i = '0;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_state", state_dbg_o, 0);
        chk("rst_a", a_o, 0);
        chk("rst_b", b_o, 0);
        chk("rst_result", result_o, 0);
        chk("rst_valid", result_valid_o, 0);

        // Table-driven additions, chained IDLE -> ... -> DONE -> GOT_A.
        for (int i = 0; i < 5; i++) begin
            logic [WIDTH-1:0] old_b;
            old_b = b_o;
            press_a(vecs[i].a);
            chk("b_retained", b_o, old_b);
            press_b(vecs[i].b, vecs[i].exp);
        end

        // Held button yields a single capture.
        reset = 1'b1;
        step(1);
        reset     = 1'b0;
        data_in_i = 5'd6;
        load_i    = 1'b1;
        step(50);
        chk("hold_state", state_dbg_o, 1);
        chk("hold_a", a_o, 6);
        load_i = 1'b0;
        step(3);
        press_b(5'd3, 6'd9);

        // New press from DONE: valid drops, result held.
        press_a(5'd9);
        press_b(5'd4, 6'd13);
        press_a(5'd7);
        chk("redo_result_held", result_o, 13);
        chk("redo_state", state_dbg_o, 1);

        // Reset while in GOT_A.
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("rstga_state", state_dbg_o, 0);
        chk("rstga_result", result_o, 0);
        chk("rstga_a", a_o, 0);

        // Reset on the ADD cycle beats the result capture.
        press_a(5'd5);
        data_in_i = 5'd2;
        load_i    = 1'b1;
        step(3);
        chk("rstadd_pre", state_dbg_o, 2);
        reset  = 1'b1;
        load_i = 1'b0;
        step(1);
        reset = 1'b0;
        chk("rstadd_state", state_dbg_o, 0);
        chk("rstadd_result", result_o, 0);
        chk("rstadd_valid", result_valid_o, 0);
        chk("rstadd_b", b_o, 0);
        step(4);
        chk("rstadd_idle", state_dbg_o, 0);

        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
